// File: rtl/memory_access_pkg.sv
// Shared processor definitions for the memory-access stage: opcode constants,
// opcode field position and the stage FSM state encoding.
package memory_access_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;

    localparam logic [4:0] OP_LW       = 5'd0;
    localparam logic [4:0] OP_SW       = 5'd1;
    localparam logic [4:0] OP_DATA_MIN = 5'd2;
    localparam logic [4:0] OP_DATA_MAX = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    function automatic logic [4:0] get_opcode(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic is_mem_op(input logic [4:0] opc);
        return (opc == OP_LW) || (opc == OP_SW);
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Execute -> memory-access -> write-back handshake plus the data-memory bus.
// The slave modport is the memory-access stage; master is its environment.
interface memory_access_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic [31:0] store_data;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_data;
    logic [31:0] out_mem_data;
    logic        mem_error;

    modport slave (
        input  in_valid, instruction, alu_result, store_data,
        input  mem_rdata, mem_ack, out_ready,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output out_valid, out_instruction, out_data, out_mem_data, mem_error
    );

    modport master (
        output in_valid, instruction, alu_result, store_data,
        output mem_rdata, mem_ack, out_ready,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  out_valid, out_instruction, out_data, out_mem_data, mem_error
    );

endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: single-entry buffer issuing LW/SW to data memory.
// Optional ack timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for an instruction from execute
// REQ   | first cycle of a memory request
// WAIT  | request held, waiting for mem_ack
// HOLD  | result presented to write-back until out_ready
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    memory_access_if.slave bus
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_instr;
    logic [31:0] r_data;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_data;
    logic        r_is_sw;
    logic        w_busy;
    logic        w_timeout;

    assign w_busy = (r_state == ST_REQ) || (r_state == ST_WAIT);

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [31:0] r_count;
    logic        r_mem_error;

    // Down-counter loaded while idle; terminal count in a request cycle without ack aborts.
    assign w_timeout = w_busy && !bus.mem_ack && (r_count == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 32'd0;
            r_mem_error <= 1'b0;
        end else begin
            r_mem_error <= w_timeout;
            if (r_state == ST_IDLE) begin
                r_count <= 32'(TIMEOUT_CYCLES - 1);
            end else if (w_busy && (r_count != 32'd0)) begin
                r_count <= r_count - 32'd1;
            end
        end
    end

    assign bus.mem_error = r_mem_error;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign bus.mem_error    = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = is_mem_op(get_opcode(bus.instruction)) ? ST_REQ : ST_HOLD;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (bus.mem_ack || w_timeout) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_instr    <= 32'd0;
            r_data     <= 32'd0;
            r_wdata    <= 32'd0;
            r_mem_data <= 32'd0;
            r_is_sw    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_instr    <= bus.instruction;
                        r_data     <= bus.alu_result;
                        r_wdata    <= bus.store_data;
                        r_is_sw    <= (get_opcode(bus.instruction) == OP_SW);
                        r_mem_data <= 32'd0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (bus.mem_ack) begin
                        r_mem_data <= r_is_sw ? r_wdata : bus.mem_rdata;
                    end else if (w_timeout) begin
                        r_mem_data <= 32'hFFFF_FFFF;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready        = (r_state == ST_IDLE);
    assign bus.mem_req         = w_busy;
    assign bus.mem_we          = w_busy && r_is_sw;
    assign bus.mem_addr        = r_data;
    assign bus.mem_wdata       = r_wdata;
    assign bus.out_valid       = (r_state == ST_HOLD);
    assign bus.out_instruction = r_instr;
    assign bus.out_data        = r_data;
    assign bus.out_mem_data    = r_mem_data;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_memory_access;

    localparam int unsigned TO_CYC = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    memory_access_if bus();

    memory_access #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what write-back must see for a completed instruction.
    function automatic logic [31:0] model_mem_data(input logic [31:0] instr,
                                                   input logic [31:0] sd,
                                                   input logic [31:0] rdata);
        int opc;
        opc = int'(instr >> 27);
        if (opc == 0) return rdata;
        if (opc == 1) return sd;
        return 32'd0;
    endfunction

    task automatic run_txn(input logic [31:0] instr, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [31:0] rdata,
                           input int delay, input int stall);
        int          opc;
        logic [31:0] exp_md;
        opc    = int'(instr >> 27);
        exp_md = model_mem_data(instr, sd, rdata);

        check_eq("idle_in_ready", bus.in_ready, 1);
        bus.in_valid    = 1'b1;
        bus.instruction = instr;
        bus.alu_result  = alu;
        bus.store_data  = sd;
        tick();
        bus.in_valid    = 1'b0;
        bus.instruction = $urandom;
        bus.alu_result  = $urandom;
        bus.store_data  = $urandom;

        if (opc < 2) begin
            for (int k = 0; k <= delay; k++) begin
                check_eq("req_mem_req", bus.mem_req, 1);
                check_eq("req_mem_addr", bus.mem_addr, alu);
                check_eq("req_mem_we", bus.mem_we, (opc == 1) ? 1 : 0);
                if (opc == 1) check_eq("req_mem_wdata", bus.mem_wdata, sd);
                check_eq("req_out_valid", bus.out_valid, 0);
                check_eq("req_in_ready", bus.in_ready, 0);
                check_eq("req_mem_error", bus.mem_error, 0);
                if (k == delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
                tick();
            end
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end

        check_eq("hold_out_valid", bus.out_valid, 1);
        check_eq("hold_mem_req", bus.mem_req, 0);
        check_eq("hold_out_instr", bus.out_instruction, instr);
        check_eq("hold_out_data", bus.out_data, alu);
        check_eq("hold_out_mem_data", bus.out_mem_data, exp_md);

        bus.out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            bus.in_valid    = 1'b1;
            bus.instruction = $urandom;
            bus.mem_ack     = 1'b1;
            tick();
            check_eq("stall_out_valid", bus.out_valid, 1);
            check_eq("stall_in_ready", bus.in_ready, 0);
            check_eq("stall_mem_req", bus.mem_req, 0);
            check_eq("stall_out_instr", bus.out_instruction, instr);
            check_eq("stall_out_data", bus.out_data, alu);
            check_eq("stall_out_mem_data", bus.out_mem_data, exp_md);
        end
        bus.in_valid  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("drain_out_valid", bus.out_valid, 0);
        check_eq("drain_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] instr;
        int          sel;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = 32'd0;
        bus.alu_result  = 32'd0;
        bus.store_data  = 32'd0;
        bus.mem_rdata   = 32'd0;
        bus.mem_ack     = 1'b0;
        bus.out_ready   = 1'b0;
        #2;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_mem_req", bus.mem_req, 0);
        check_eq("rst_mem_we", bus.mem_we, 0);
        check_eq("rst_mem_error", bus.mem_error, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
        check_eq("rst_out_instr", bus.out_instruction, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_out_mem_data", bus.out_mem_data, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // data op, opcode 5, accepted on the first edge after reset release
        run_txn(32'h2800_0000, 32'h1234_5678, 32'h0, 32'h0, 0, 0);
        // LW with ack after 3 wait cycles
        run_txn(32'h0000_AAAA, 32'h0000_0100, 32'h0, 32'h8F38_FAAA, 3, 0);
        // SW zero-wait
        run_txn(32'h0800_AAAA, 32'h0000_0040, 32'hF238_FAAA, 32'h5555_5555, 0, 0);
        // backpressure for 5 cycles
        run_txn(32'h9000_0001, 32'hCAFE_0001, 32'h0, 32'h0, 0, 5);
        run_txn(32'h0000_0123, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 1, 5);

        // reset during an LW wait
        bus.in_valid    = 1'b1;
        bus.instruction = 32'h0000_1234;
        bus.alu_result  = 32'h0000_0300;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check_eq("midwait_mem_req", bus.mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_mem_req", bus.mem_req, 0);
        check_eq("arst_out_valid", bus.out_valid, 0);
        check_eq("arst_mem_addr", bus.mem_addr, 0);
        tick();
        rst_n         = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        tick();
        bus.mem_ack = 1'b0;
        check_eq("stray_ack_in_ready", bus.in_ready, 1);
        check_eq("stray_ack_out_valid", bus.out_valid, 0);
        check_eq("stray_ack_mem_req", bus.mem_req, 0);
        check_eq("stray_ack_mem_data", bus.out_mem_data, 0);

        // LW that never gets an ack
        bus.in_valid    = 1'b1;
        bus.instruction = 32'h0000_0777;
        bus.alu_result  = 32'h0000_0400;
        tick();
        bus.in_valid = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        for (int k = 0; k < int'(TO_CYC); k++) begin
            check_eq("to_mem_req", bus.mem_req, 1);
            check_eq("to_mem_error_low", bus.mem_error, 0);
            tick();
        end
        check_eq("to_mem_req_drop", bus.mem_req, 0);
        check_eq("to_mem_error_pulse", bus.mem_error, 1);
        check_eq("to_out_valid", bus.out_valid, 1);
        check_eq("to_out_mem_data", bus.out_mem_data, 32'hFFFF_FFFF);
        tick();
        check_eq("to_mem_error_single", bus.mem_error, 0);
        check_eq("to_out_valid_held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
`else
        for (int k = 0; k < 20; k++) begin
            check_eq("noack_mem_req", bus.mem_req, 1);
            check_eq("noack_mem_error", bus.mem_error, 0);
            tick();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        bus.mem_ack = 1'b0;
        check_eq("noack_late_data", bus.out_mem_data, 32'h0BAD_F00D);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
`endif
        check_eq("post_to_in_ready", bus.in_ready, 1);

        for (int t = 0; t < 40; t++) begin
            sel   = int'($urandom_range(0, 3));
            instr = $urandom;
            if (sel == 0) instr[31:27] = 5'd0;
            else if (sel == 1) instr[31:27] = 5'd1;
            else instr[31:27] = 5'($urandom_range(2, 31));
            if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
                tick();
                bus.mem_ack = 1'b0;
                check_eq("idle_ack_mem_req", bus.mem_req, 0);
                check_eq("idle_ack_out_valid", bus.out_valid, 0);
            end
            run_txn(instr, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
